// File: rtl/data8out_arb.sv
// data8out_arb: round-robin scheduler sharing one data8out byte serializer
// among NREQ word producers. One word is captured per grant, the serializer
// load strobe is pulsed, and the next grant waits for the serializer to finish.
// Optional WAIT-state watchdog enabled by defining DATA8OUT_ARB_WDOG_EN.
module data8out_arb #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned WIDTH   = 40,
    parameter int unsigned IDW     = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  pclk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       ack,
    output logic [WIDTH-1:0]      ser_din,
    output logic                  ser_start,
    input  logic                  ser_ready,
    output logic                  busy,
    output logic [IDW-1:0]        cur_id,
    output logic [15:0]           word_cnt,
    output logic                  err
);

    localparam int unsigned CNT_W  = 16;
    localparam bit          CFG_OK = (NREQ >= 2) && (NREQ <= 8) &&
                                     ((1 << IDW) >= NREQ) && (TIMEOUT >= 1);

    // Reject parameter sets the round-robin search and watchdog cannot support
    if (!CFG_OK) begin : g_cfg_check
        $error("data8out_arb: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2,
        S_WAIT = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [NREQ-1:0]    ack_q, ack_d;
    logic [WIDTH-1:0]   ser_din_q, ser_din_d;
    logic               ser_start_q, ser_start_d;
    logic               busy_q, busy_d;
    logic [IDW-1:0]     cur_id_q, cur_id_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               err_q, err_d;

`ifdef DATA8OUT_ARB_WDOG_EN
    localparam int unsigned WDW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [WDW-1:0]     wd_cnt_q, wd_cnt_d;
`endif

    logic               hi_vld_c, lo_vld_c;
    logic [IDW-1:0]     hi_id_c, lo_id_c;
    logic               grant_vld_c;
    logic [IDW-1:0]     grant_id_c;
    logic [WIDTH-1:0]   din_sel_c;

    // Round-robin pick: lowest requester above cur_id, else lowest at or below it
    always_comb begin
        hi_vld_c = 1'b0;
        lo_vld_c = 1'b0;
        hi_id_c  = '0;
        lo_id_c  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (req[i]) begin
                if (IDW'(i) > cur_id_q) begin
                    if (!hi_vld_c) begin
                        hi_vld_c = 1'b1;
                        hi_id_c  = IDW'(i);
                    end
                end else if (!lo_vld_c) begin
                    lo_vld_c = 1'b1;
                    lo_id_c  = IDW'(i);
                end
            end
        end
        grant_vld_c = hi_vld_c | lo_vld_c;
        grant_id_c  = hi_vld_c ? hi_id_c : lo_id_c;
    end

    // Select the winner's word slice
    always_comb begin
        din_sel_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_id_c == IDW'(i)) begin
                din_sel_c = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        ack_d       = '0;
        ser_start_d = 1'b0;
        ser_din_d   = ser_din_q;
        cur_id_d    = cur_id_q;
        word_cnt_d  = word_cnt_q;
        err_d       = err_q;
`ifdef DATA8OUT_ARB_WDOG_EN
        wd_cnt_d    = wd_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ser_ready && grant_vld_c) begin
                    ser_din_d   = din_sel_c;
                    cur_id_d    = grant_id_c;
                    ack_d       = NREQ'(1) << grant_id_c;
                    ser_start_d = 1'b1;
                    state_d     = S_LOAD;
                end
            end
            S_LOAD: begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
                state_d    = S_HOLD;
            end
            S_HOLD: begin
                // serializer ready drops one cycle after the strobe; ignore it here
                state_d = S_WAIT;
`ifdef DATA8OUT_ARB_WDOG_EN
                wd_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (ser_ready) begin
                    state_d = S_IDLE;
                end
`ifdef DATA8OUT_ARB_WDOG_EN
                else if (wd_cnt_q == WDW'(TIMEOUT - 1)) begin
                    // serializer never finished: drop the word and flag it
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + WDW'(1);
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ack_q       <= '0;
            ser_din_q   <= '0;
            ser_start_q <= 1'b0;
            busy_q      <= 1'b0;
            cur_id_q    <= IDW'(NREQ - 1);
            word_cnt_q  <= '0;
            err_q       <= 1'b0;
`ifdef DATA8OUT_ARB_WDOG_EN
            wd_cnt_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ack_q       <= ack_d;
            ser_din_q   <= ser_din_d;
            ser_start_q <= ser_start_d;
            busy_q      <= busy_d;
            cur_id_q    <= cur_id_d;
            word_cnt_q  <= word_cnt_d;
            err_q       <= err_d;
`ifdef DATA8OUT_ARB_WDOG_EN
            wd_cnt_q    <= wd_cnt_d;
`endif
        end
    end

    assign ack       = ack_q;
    assign ser_din   = ser_din_q;
    assign ser_start = ser_start_q;
    assign busy      = busy_q;
    assign cur_id    = cur_id_q;
    assign word_cnt  = word_cnt_q;
    assign err       = err_q;

endmodule
